// File: rtl/byte_mask_memory_if.sv
// Enable/write-strobe bus for byte_mask_memory: word address, write data,
// per-byte write enables and the registered read data coming back.
interface byte_mask_memory_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
);
  localparam int NBYTES = DATA_W / 8;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              enb;
  logic              wr;
  logic [NBYTES-1:0] masked;
  logic [DATA_W-1:0] r_data;

  modport master (output addr, data, enb, wr, masked, input r_data);
  modport slave  (input addr, data, enb, wr, masked, output r_data);
endinterface

// File: rtl/byte_mask_memory.sv
// Single-port RAM with per-byte write enables and one-cycle registered read.
// Define BMM_CLEAR_ON_RST_EN to make reset also zero every word of the array.
module byte_mask_memory #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  byte_mask_memory_if.slave  bus
);
  localparam int NBYTES = DATA_W / 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              w_wr_en;
  logic              w_rd_en;

  // Reset takes priority, so an access on a reset edge is dropped entirely.
  assign w_wr_en = bus.enb & bus.wr & ~i_rst;
  assign w_rd_en = bus.enb & ~bus.wr & ~i_rst;

`ifdef BMM_CLEAR_ON_RST_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int w = 0; w < DEPTH; w++) begin
        r_mem[w] <= '0;
      end
    end else if (w_wr_en) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (bus.masked[b]) begin
          r_mem[bus.addr][8*b +: 8] <= bus.data[8*b +: 8];
        end
      end
    end
  end
`else
  // No reset on the array so it stays inferable as RAM; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (bus.masked[b]) begin
          r_mem[bus.addr][8*b +: 8] <= bus.data[8*b +: 8];
        end
      end
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data <= '0;
    end else if (w_rd_en) begin
      r_rd_data <= r_mem[bus.addr];
    end
  end

  assign bus.r_data = r_rd_data;
endmodule

// File: tb/tb_byte_mask_memory.sv
// Self-checking bench for byte_mask_memory: vector table driven through a
// scoreboard queue, plus hand-written clear and read-latency sequences.
module tb_byte_mask_memory;
  logic i_clk = 1'b0;
  logic i_rst = 1'b0;

  byte_mask_memory_if #(.ADDR_W(3), .DATA_W(32)) bus_if ();

  byte_mask_memory #(.ADDR_W(3), .DATA_W(32)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus_if)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        enb;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [3:0]  masked;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

`ifdef BMM_CLEAR_ON_RST_EN
  localparam logic [31:0] EXP_A2_AFTER_RST = 32'h0000_0000;
  localparam logic [31:0] EXP_A3_AFTER_RST = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_A2_AFTER_RST = 32'h5A5A_5A5A;
  localparam logic [31:0] EXP_A3_AFTER_RST = 32'hDEAD_BEEF;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];
  sb_t  sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic rst, input logic enb,
                              input logic wr, input logic [2:0] addr, input logic [31:0] data,
                              input logic [3:0] masked, input logic [31:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.enb = enb; v.wr = wr;
    v.addr = addr; v.data = data; v.masked = masked; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic enb, input logic wr,
                       input logic [2:0] addr, input logic [31:0] data, input logic [3:0] masked);
    i_rst         = rst;
    bus_if.enb    = enb;
    bus_if.wr     = wr;
    bus_if.addr   = addr;
    bus_if.data   = data;
    bus_if.masked = masked;
  endtask

  // Drive one cycle, queue the expectation, compare after the edge.
  task automatic apply(input vec_t v);
    sb_t e;
    drive(v.rst, v.enb, v.wr, v.addr, v.data, v.masked);
    e.name = v.name;
    e.exp  = v.exp;
    sb_q.push_back(e);
    @(posedge i_clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb_q.pop_front();
      check(e.name, bus_if.r_data, e.exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    @(posedge i_clk);
    #1;

`ifdef BMM_CLEAR_ON_RST_EN
    apply(mk("clr_rst", 1, 0, 0, 3'd0, 32'h0, 4'h0, 32'h0));
    for (int a = 0; a < 8; a++) begin
      apply(mk($sformatf("clr_read_a%0d", a), 0, 1, 0, 3'(a), 32'h0, 4'h0, 32'h0));
    end
`endif

    vecs.push_back(mk("reset",          1, 0, 0, 3'd0, 32'h0000_0000, 4'h0, 32'h0000_0000));
    vecs.push_back(mk("init_a0",        0, 1, 1, 3'd0, 32'h0000_0000, 4'hF, 32'h0000_0000));
    vecs.push_back(mk("wr_low_a0",      0, 1, 1, 3'd0, 32'h0000_000E, 4'h3, 32'h0000_0000));
    vecs.push_back(mk("rd_low_a0",      0, 1, 0, 3'd0, 32'h0000_0000, 4'h0, 32'h0000_000E));
    vecs.push_back(mk("wr_full_a7",     0, 1, 1, 3'd7, 32'hAABB_CCDD, 4'hF, 32'h0000_000E));
    vecs.push_back(mk("wr_merge_a7",    0, 1, 1, 3'd7, 32'h1122_3344, 4'h5, 32'h0000_000E));
    vecs.push_back(mk("rd_merge_a7",    0, 1, 0, 3'd7, 32'h0000_0000, 4'h0, 32'hAA22_CC44));
    vecs.push_back(mk("wr_full_a3",     0, 1, 1, 3'd3, 32'hDEAD_BEEF, 4'hF, 32'hAA22_CC44));
    vecs.push_back(mk("wr_nomask_a3",   0, 1, 1, 3'd3, 32'h1234_5678, 4'h0, 32'hAA22_CC44));
    vecs.push_back(mk("rd_a3",          0, 1, 0, 3'd3, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF));
    vecs.push_back(mk("idle_1",         0, 0, 1, 3'd7, 32'hFFFF_FFFF, 4'hF, 32'hDEAD_BEEF));
    vecs.push_back(mk("idle_2",         0, 0, 0, 3'd0, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF));
    vecs.push_back(mk("idle_3",         0, 0, 0, 3'd7, 32'h5555_5555, 4'hA, 32'hDEAD_BEEF));
    vecs.push_back(mk("rd_a0_maskign",  0, 1, 0, 3'd0, 32'hFFFF_FFFF, 4'hF, 32'h0000_000E));
    vecs.push_back(mk("wr_hold_a0",     0, 1, 1, 3'd0, 32'hFFFF_FFFF, 4'h8, 32'h0000_000E));
    vecs.push_back(mk("rd_top_a0",      0, 1, 0, 3'd0, 32'h0000_0000, 4'h0, 32'hFF00_000E));
    vecs.push_back(mk("wr_full_a5",     0, 1, 1, 3'd5, 32'h0102_0304, 4'hF, 32'hFF00_000E));
    vecs.push_back(mk("wr_mid_a5",      0, 1, 1, 3'd5, 32'hA0B0_C0D0, 4'h6, 32'hFF00_000E));
    vecs.push_back(mk("rd_mid_a5",      0, 1, 0, 3'd5, 32'h0000_0000, 4'h0, 32'h01B0_C004));
    vecs.push_back(mk("rd_a7_again",    0, 1, 0, 3'd7, 32'h0000_0000, 4'h0, 32'hAA22_CC44));
    vecs.push_back(mk("wr_full_a2",     0, 1, 1, 3'd2, 32'h5A5A_5A5A, 4'hF, 32'hAA22_CC44));
    vecs.push_back(mk("rst_during_wr",  1, 1, 1, 3'd2, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000));
    vecs.push_back(mk("rd_a2_post_rst", 0, 1, 0, 3'd2, 32'h0000_0000, 4'h0, EXP_A2_AFTER_RST));
    vecs.push_back(mk("rd_a3_post_rst", 0, 1, 0, 3'd3, 32'h0000_0000, 4'h0, EXP_A3_AFTER_RST));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      apply(v);
    end

    // Read latency: the new word appears only after the sampling edge,
    // and a following write leaves r_data alone.
    apply(mk("lat_wr_a1", 0, 1, 1, 3'd1, 32'h1357_9BDF, 4'hF, EXP_A3_AFTER_RST));
    drive(1'b0, 1'b1, 1'b0, 3'd1, 32'h0, 4'h0);
    #3;
    check("lat_before_edge", bus_if.r_data, EXP_A3_AFTER_RST);
    @(posedge i_clk);
    #1;
    check("lat_after_edge", bus_if.r_data, 32'h1357_9BDF);
    drive(1'b0, 1'b1, 1'b1, 3'd1, 32'h2468_ACE0, 4'hF);
    #3;
    check("lat_no_comb_path", bus_if.r_data, 32'h1357_9BDF);
    @(posedge i_clk);
    #1;
    check("lat_wr_hold", bus_if.r_data, 32'h1357_9BDF);
    apply(mk("lat_rd_new_a1", 0, 1, 0, 3'd1, 32'h0, 4'h0, 32'h2468_ACE0));

    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
